// File: rtl/led_pkg.sv
// Shared definitions for the LED blink-rate decoder: base count, divider range,
// counter type, FSM state encoding and the expected-interval table builder.
package led_pkg;

  localparam int unsigned CNT_1S  = 100_000_000;
  localparam int unsigned DIV_MAX = 20;
  localparam int unsigned CNT_W   = 28;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_SEARCH  = 2'd2,
    ST_REPORT  = 2'd3
  } led_state_e;

  // Entry d holds the toggle interval produced by divider d: base/d + 1.
  typedef logic [DIV_MAX:1][CNT_W-1:0] exp_tab_t;

  function automatic exp_tab_t build_exp_tab(input int unsigned base);
    exp_tab_t tab;
    tab = '0;
    for (int unsigned d = 1; d <= DIV_MAX; d++) begin
      tab[d[4:0]] = cnt_t'(base / d + 1);
    end
    return tab;
  endfunction

endpackage

// File: rtl/led_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin followed by a registered
// toggle detect: one-cycle pulse on every rise or fall of the synchronized level.
module led_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_toggle
);

  logic r_meta;
  logic r_sync;
  logic r_level;
  logic r_toggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_level  <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_level  <= r_sync;
      r_toggle <= r_sync ^ r_level;
    end
  end

  assign o_toggle = r_toggle;

endmodule

// File: rtl/led_rate_dec.sv
// LED blink-rate decoder: measures the toggle interval of led_i and matches it
// against CNT_BASE/d + 1 for d = 1..20. Define LED_RATE_DEC_PERIOD_EN for period_o.
module led_rate_dec
  import led_pkg::*;
#(
  parameter int unsigned CNT_BASE = CNT_1S,
  parameter int unsigned TOL_CYC  = 16
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic        led_i,
  output logic [4:0]  div_o,
  output logic        lock_o,
  output logic        valid_o,
  output logic        timeout_o
`ifdef LED_RATE_DEC_PERIOD_EN
  ,
  output logic [27:0] period_o
`endif
);

  localparam exp_tab_t       EXP   = build_exp_tab(CNT_BASE);
  localparam cnt_t           T_OUT = cnt_t'(2 * CNT_BASE);
  localparam logic [CNT_W:0] TOL   = (CNT_W + 1)'(TOL_CYC);
  localparam logic [4:0]     D_MAX = 5'(DIV_MAX);

  logic           w_toggle;
  logic [CNT_W:0] w_exp;
  logic [CNT_W:0] w_int;
  logic           w_match;
  logic           w_done;

  led_state_e     r_state;
  cnt_t           r_cnt;
  cnt_t           r_interval;
  logic [4:0]     r_idx;
  logic [4:0]     r_div;
  logic           r_lock;
  logic           r_valid;
  logic           r_timeout;

  led_sync_edge u_sync (
    .clk      (clk100),
    .rst_n    (rst_n),
    .i_async  (led_i),
    .o_toggle (w_toggle)
  );

  // r_idx walks the table 1..DIV_MAX, one entry per SEARCH cycle.
  assign w_exp   = {1'b0, EXP[r_idx]};
  assign w_int   = {1'b0, r_interval};
  assign w_match = (w_int + TOL >= w_exp) && (w_int <= w_exp + TOL);
  assign w_done  = (r_state == ST_SEARCH) && !w_toggle && (w_match || (r_idx == D_MAX));

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_interval <= '0;
      r_idx      <= 5'd1;
      r_div      <= '0;
      r_lock     <= 1'b0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (w_toggle) begin
        r_cnt     <= cnt_t'(1);
        r_timeout <= 1'b0;
      end else if (r_state != ST_IDLE && r_cnt != T_OUT) begin
        r_cnt <= r_cnt + cnt_t'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_toggle) begin
            r_state <= ST_MEASURE;
          end
        end

        ST_MEASURE, ST_REPORT: begin
          if (w_toggle) begin
            r_interval <= r_cnt;
            r_idx      <= 5'd1;
            r_state    <= ST_SEARCH;
          end else if (r_state == ST_MEASURE && r_cnt == T_OUT) begin
            r_timeout <= 1'b1;
            r_lock    <= 1'b0;
            r_div     <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_state <= ST_MEASURE;
          end
        end

        ST_SEARCH: begin
          // A new toggle abandons the current interval and restarts on the new one.
          if (w_toggle) begin
            r_interval <= r_cnt;
            r_idx      <= 5'd1;
          end else if (w_done) begin
            r_valid <= 1'b1;
            r_div   <= w_match ? r_idx : 5'd0;
            r_lock  <= w_match;
            r_state <= ST_REPORT;
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LED_RATE_DEC_PERIOD_EN
  logic [27:0] r_period;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
    end else if (w_done) begin
      r_period <= r_interval;
    end
  end

  assign period_o = r_period;
`endif

  assign div_o     = r_div;
  assign lock_o    = r_lock;
  assign valid_o   = r_valid;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_led_rate_dec.sv
// Randomized bench for led_rate_dec with CNT_BASE = 1000, TOL_CYC = 1, checked
// every cycle against an event-level model of the decode rules.
`timescale 1ns/1ps
module tb_led_rate_dec;

  localparam int CNT_BASE = 1000;
  localparam int TOL      = 1;
  localparam int T_OUT    = 2 * CNT_BASE;

  logic        clk100 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        led_i  = 1'b0;
  logic [4:0]  div_o;
  logic        lock_o;
  logic        valid_o;
  logic        timeout_o;
`ifdef LED_RATE_DEC_PERIOD_EN
  logic [27:0] period_o;
`endif

  led_rate_dec #(
    .CNT_BASE (CNT_BASE),
    .TOL_CYC  (TOL)
  ) dut (
    .clk100    (clk100),
    .rst_n     (rst_n),
    .led_i     (led_i),
    .div_o     (div_o),
    .lock_o    (lock_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o)
`ifdef LED_RATE_DEC_PERIOD_EN
    ,
    .period_o  (period_o)
`endif
  );

  always #5 clk100 = ~clk100;

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Model: toggle events are known cycles; each interval decodes to the first d
  // within tolerance, reported 2+k cycles after its event unless aborted.
  int q_ev[$];
  bit m_armed;
  int m_last;
  bit m_pend;
  int m_pend_cyc, m_pend_div, m_pend_int;
  int m_div, m_lock, m_timeout, m_period;

  function automatic int decode(input int gap);
    for (int d = 1; d <= 20; d++) begin
      int e;
      int diff;
      e    = CNT_BASE / d + 1;
      diff = gap - e;
      if (diff >= -TOL && diff <= TOL) return d;
    end
    return 0;
  endfunction

  task automatic model_reset();
    q_ev.delete();
    m_armed = 0; m_last = 0; m_pend = 0;
    m_pend_cyc = 0; m_pend_div = 0; m_pend_int = 0;
    m_div = 0; m_lock = 0; m_timeout = 0; m_period = 0;
  endtask

  task automatic step();
    bit exp_valid;
    @(negedge clk100);
    exp_valid = 0;
    if (q_ev.size() > 0 && q_ev[0] == cyc - 1) begin
      void'(q_ev.pop_front());
      if (m_armed) begin
        int gap;
        int d;
        gap        = (cyc - 1) - m_last;
        d          = decode(gap);
        m_pend     = 1;
        m_pend_div = d;
        m_pend_int = gap;
        m_pend_cyc = cyc + 1 + ((d != 0) ? d - 1 : 19);
      end
      m_armed   = 1;
      m_last    = cyc - 1;
      m_timeout = 0;
    end else if (m_armed && cyc == m_last + T_OUT + 1) begin
      m_timeout = 1; m_div = 0; m_lock = 0; m_armed = 0; m_pend = 0;
      $display("timeout cyc=%0d timeout_o=%0d div_o=%0d lock_o=%0d", cyc, timeout_o, div_o, lock_o);
    end
    if (m_pend && m_pend_cyc == cyc) begin
      exp_valid = 1;
      m_div     = m_pend_div;
      m_lock    = (m_pend_div != 0);
      m_period  = m_pend_int;
      m_pend    = 0;
      $display("strobe cyc=%0d interval=%0d div_o=%0d lock_o=%0d exp_div=%0d",
               cyc, m_pend_int, div_o, lock_o, m_div);
    end
    check_eq("valid",   32'(valid_o),   32'(exp_valid));
    check_eq("timeout", 32'(timeout_o), 32'(m_timeout));
    check_eq("div",     32'(div_o),     32'(m_div));
    check_eq("lock",    32'(lock_o),    32'(m_lock));
`ifdef LED_RATE_DEC_PERIOD_EN
    check_eq("period",  32'(period_o),  32'(m_period));
`endif
  endtask

  // Toggle led_i n cycles after the previous toggle; the event lands 3 cycles later.
  task automatic gap_toggle(input int n);
    repeat (n) step();
    led_i = ~led_i;
    q_ev.push_back(cyc + 3);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_div"},     32'(div_o),     32'd0);
    check_eq({tag, "_lock"},    32'(lock_o),    32'd0);
    check_eq({tag, "_valid"},   32'(valid_o),   32'd0);
    check_eq({tag, "_timeout"}, 32'(timeout_o), 32'd0);
`ifdef LED_RATE_DEC_PERIOD_EN
    check_eq({tag, "_period"},  32'(period_o),  32'd0);
`endif
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk100);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    led_i = 1'b0;
    model_reset();
    repeat (hold) @(negedge clk100);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk100);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) step();

    // Base rate: first edge arms, later edges decode d = 1.
    gap_toggle(10);
    repeat (4) gap_toggle(1001);

    // Fastest entry and tolerance edges.
    repeat (3) gap_toggle(51);
    repeat (3) gap_toggle(52);
    repeat (3) gap_toggle(53);

    // Out of table: full search, d = 0.
    repeat (3) gap_toggle(1003);

    // Re-lock then starve the line into timeout.
    repeat (2) gap_toggle(1001);
    gap_toggle(2100);
    gap_toggle(1001);
    gap_toggle(1001);
    gap_toggle(1999);

    // Abort: second edge 5 cycles into a 20-step search.
    gap_toggle(1001);
    gap_toggle(1003);
    gap_toggle(5);
    gap_toggle(1001);
    repeat (40) step();

    // Reset in the middle of a search.
    gap_toggle(1001);
    gap_toggle(1003);
    repeat (7) step();
    do_reset(4);
    repeat (5) step();
    gap_toggle(20);
    gap_toggle(1001);
    gap_toggle(501);

    // Randomized intervals: near table entries, arbitrary, short, and long.
    for (int i = 0; i < 50; i++) begin
      int sel;
      int g;
      sel = int'($urandom_range(0, 9));
      if (sel < 5) begin
        int d;
        d = int'($urandom_range(1, 20));
        g = CNT_BASE / d + 1 + int'($urandom_range(0, 4)) - 2;
      end else if (sel < 8) begin
        g = int'($urandom_range(2, 1100));
      end else if (sel < 9) begin
        g = int'($urandom_range(2, 30));
      end else begin
        g = int'($urandom_range(2010, 2200));
      end
      gap_toggle(g);
    end
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
